irq27_sequencer: RTL and testbench

Sequential front-end for the 27-channel interrupt priority logic: 3 request buses (A, B, C) × 9 channels, with a shared 9-bit channel enable.
- Captures requests into sticky pending registers.
- Arbitrates with fixed bus priority A > B > C, lowest channel index first within a bus, plus anti-starvation aging for B and C.
- Presents one grant at a time over a valid/ready handshake to the downstream service unit.

---
 rtl/irq27_pkg.sv | 36 +++
 rtl/irq27_pick.sv | 53 +++++
 rtl/irq27_sequencer.sv | 140 ++++++++++++++
 tb/tb_irq27_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq27_pkg.sv
// Shared types and constants for the 27-channel interrupt sequencer.
package irq27_pkg;

  localparam int unsigned DefNch    = 9;
  localparam int unsigned DefAgeMax = 15;
  localparam int unsigned AgeW      = 4;

  typedef logic [3:0]      chan_idx_t;
  typedef logic [1:0]      bus_id_t;
  typedef logic [AgeW-1:0] age_t;

  localparam bus_id_t BUS_A = 2'd0;
  localparam bus_id_t BUS_B = 2'd1;
  localparam bus_id_t BUS_C = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StOffer,
    StRetire
  } state_e;

  // Anti-starvation counter step: reset on grant, count bypassed arbitrations, saturate.
  function automatic age_t age_step(input age_t age, input logic granted, input logic was_elig,
                                    input age_t age_max);
    age_t nxt;
    nxt = age;
    if (granted) begin
      nxt = '0;
    end else if (was_elig && (age != age_max)) begin
      nxt = age + age_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/irq27_pick.sv
// Combinational winner selection: fixed bus priority A > B > C with aging override,
// lowest channel index within the chosen bus.
module irq27_pick
  import irq27_pkg::*;
#(
  parameter int unsigned NCH = DefNch
) (
  input  logic [NCH-1:0] elig_a_i,
  input  logic [NCH-1:0] elig_b_i,
  input  logic [NCH-1:0] elig_c_i,
  input  logic           age_b_sat_i,
  input  logic           age_c_sat_i,
  output logic           found_o,
  output bus_id_t        bus_o,
  output chan_idx_t      chan_o
);

  logic [NCH-1:0] sel;

  always_comb begin
    sel   = elig_a_i;
    bus_o = BUS_A;
    if (age_c_sat_i && (|elig_c_i)) begin
      sel   = elig_c_i;
      bus_o = BUS_C;
    end else if (age_b_sat_i && (|elig_b_i)) begin
      sel   = elig_b_i;
      bus_o = BUS_B;
    end else if (|elig_a_i) begin
      sel   = elig_a_i;
      bus_o = BUS_A;
    end else if (|elig_b_i) begin
      sel   = elig_b_i;
      bus_o = BUS_B;
    end else if (|elig_c_i) begin
      sel   = elig_c_i;
      bus_o = BUS_C;
    end
  end

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    chan_o = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (sel[i]) begin
        chan_o = chan_idx_t'(i);
      end
    end
  end

  assign found_o = |sel;

endmodule

// File: rtl/irq27_sequencer.sv
// Sticky request capture, arbitration FSM and valid/ready grant presentation
// for three 9-channel interrupt buses.
module irq27_sequencer
  import irq27_pkg::*;
#(
  parameter int unsigned NCH     = DefNch,
  parameter int unsigned AGE_MAX = DefAgeMax
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_a_i,
  input  logic [NCH-1:0] req_b_i,
  input  logic [NCH-1:0] req_c_i,
  input  logic [NCH-1:0] en_i,
  output logic           irq_valid_o,
  input  logic           irq_ready_i,
  output logic [1:0]     irq_bus_o,
  output logic [3:0]     irq_chan_o,
  output logic           irq_any_o,
  output logic           busy_o
);

  localparam age_t AgeSat = age_t'(AGE_MAX);

  state_e         state_q;
  logic [NCH-1:0] pend_a_q, pend_b_q, pend_c_q;
  logic [NCH-1:0] pend_a_d, pend_b_d, pend_c_d;
  logic [NCH-1:0] elig_a, elig_b, elig_c;
  logic [NCH-1:0] clr_mask;
  age_t           age_b_q, age_c_q;
  logic           was_b_q, was_c_q;
  logic           valid_q, any_q;
  bus_id_t        bus_q;
  chan_idx_t      chan_q;
  logic           elig_any;
  logic           retire;

  logic      pick_found;
  bus_id_t   pick_bus;
  chan_idx_t pick_chan;

  assign elig_a   = pend_a_q & en_i;
  assign elig_b   = pend_b_q & en_i;
  assign elig_c   = pend_c_q & en_i;
  assign elig_any = (|elig_a) | (|elig_b) | (|elig_c);
  assign retire   = (state_q == StRetire);

  irq27_pick #(
    .NCH(NCH)
  ) u_pick (
    .elig_a_i   (elig_a),
    .elig_b_i   (elig_b),
    .elig_c_i   (elig_c),
    .age_b_sat_i(age_b_q == AgeSat),
    .age_c_sat_i(age_c_q == AgeSat),
    .found_o    (pick_found),
    .bus_o      (pick_bus),
    .chan_o     (pick_chan)
  );

  // Clear is applied before the OR so a request on the retire edge keeps the bit set.
  always_comb begin
    clr_mask         = '0;
    clr_mask[chan_q] = 1'b1;
    pend_a_d         = pend_a_q;
    pend_b_d         = pend_b_q;
    pend_c_d         = pend_c_q;
    if (retire) begin
      unique case (bus_q)
        BUS_A:   pend_a_d = pend_a_q & ~clr_mask;
        BUS_B:   pend_b_d = pend_b_q & ~clr_mask;
        BUS_C:   pend_c_d = pend_c_q & ~clr_mask;
        default: ;
      endcase
    end
    pend_a_d = pend_a_d | req_a_i;
    pend_b_d = pend_b_d | req_b_i;
    pend_c_d = pend_c_d | req_c_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pend_a_q <= '0;
      pend_b_q <= '0;
      pend_c_q <= '0;
      age_b_q  <= '0;
      age_c_q  <= '0;
      was_b_q  <= 1'b0;
      was_c_q  <= 1'b0;
      valid_q  <= 1'b0;
      any_q    <= 1'b0;
      bus_q    <= BUS_A;
      chan_q   <= '0;
    end else begin
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      pend_c_q <= pend_c_d;
      any_q    <= elig_any;
      unique case (state_q)
        StIdle: begin
          if (elig_any) begin
            state_q <= StArb;
          end
        end
        StArb: begin
          if (pick_found) begin
            bus_q   <= pick_bus;
            chan_q  <= pick_chan;
            was_b_q <= |elig_b;
            was_c_q <= |elig_c;
            valid_q <= 1'b1;
            state_q <= StOffer;
          end else begin
            state_q <= StIdle;
          end
        end
        StOffer: begin
          if (irq_ready_i) begin
            valid_q <= 1'b0;
            state_q <= StRetire;
          end
        end
        StRetire: begin
          age_b_q <= age_step(age_b_q, bus_q == BUS_B, was_b_q, AgeSat);
          age_c_q <= age_step(age_c_q, bus_q == BUS_C, was_c_q, AgeSat);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign irq_valid_o = valid_q;
  assign irq_bus_o   = bus_q;
  assign irq_chan_o  = chan_q;
  assign irq_any_o   = any_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_irq27_sequencer.sv
// Directed bench for irq27_sequencer: reset, ordering, enable masking, backpressure,
// aging promotion and set-wins-over-clear.
module tb_irq27_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] req_a, req_b, req_c, en;
  logic       irq_valid, irq_ready, irq_any, busy;
  logic [1:0] irq_bus;
  logic [3:0] irq_chan;

  int n_tests = 0;
  int n_fail  = 0;

  irq27_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_c_i    (req_c),
    .en_i       (en),
    .irq_valid_o(irq_valid),
    .irq_ready_i(irq_ready),
    .irq_bus_o  (irq_bus),
    .irq_chan_o (irq_chan),
    .irq_any_o  (irq_any),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle with irq_valid high, or ok=0 once the budget runs out.
  task automatic wait_grant(input int budget, output bit ok, output logic [1:0] b,
                            output logic [3:0] c);
    ok = 1'b0;
    b  = '0;
    c  = '0;
    for (int i = 0; i < budget; i++) begin
      if (!ok) begin
        if (irq_valid === 1'b1) begin
          ok = 1'b1;
          b  = irq_bus;
          c  = irq_chan;
        end else begin
          step();
        end
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    en        = '0;
    irq_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic drain();
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    en        = 9'h1FF;
    irq_ready = 1'b1;
    repeat (30) step();
  endtask

  task automatic test_reset();
    bit         ok;
    bit         seen;
    logic [1:0] b;
    logic [3:0] c;
    do_reset();
    n_tests++;
    if (irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", irq_valid);
    end
    n_tests++;
    if (irq_bus !== 2'd0) begin
      n_fail++; $display("FAIL reset_bus: got %0d want 0", irq_bus);
    end
    n_tests++;
    if (irq_chan !== 4'd0) begin
      n_fail++; $display("FAIL reset_chan: got %0d want 0", irq_chan);
    end
    n_tests++;
    if (irq_any !== 1'b0) begin
      n_fail++; $display("FAIL reset_any: got %b want 0", irq_any);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    en    = 9'h1FF;
    req_b = 9'h010;
    step();
    req_b = '0;
    wait_grant(10, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd1 || c !== 4'd4) begin
      n_fail++; $display("FAIL mid_offer_grant: got ok=%0d bus=%0d chan=%0d want 1,1,4", ok, b, c);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({irq_valid, irq_bus, irq_chan, busy} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b bus=%0d chan=%0d busy=%b want all 0",
               irq_valid, irq_bus, irq_chan, busy);
    end
    step();
    rst       = 1'b0;
    irq_ready = 1'b1;
    seen      = 1'b0;
    repeat (10) begin
      step();
      if (irq_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || irq_any !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_regrant: got seen=%b any=%b want 0,0", seen, irq_any);
    end
  endtask

  task automatic test_order();
    bit         ok;
    logic [1:0] b;
    logic [3:0] c;
    logic [1:0] exp_b [3] = '{2'd0, 2'd1, 2'd2};
    logic [3:0] exp_c [3] = '{4'd8, 4'd3, 4'd0};
    en        = 9'h1FF;
    irq_ready = 1'b1;
    req_a     = 9'h100;
    req_b     = 9'h008;
    req_c     = 9'h001;
    step();
    req_a = '0;
    req_b = '0;
    req_c = '0;
    n_tests++;
    if (irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL order_lat_t: got %b want 0", irq_valid);
    end
    step();
    n_tests++;
    if (irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL order_lat_t1: got %b want 0", irq_valid);
    end
    step();
    n_tests++;
    if (irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL order_lat_t2: got %b want 1", irq_valid);
    end
    for (int g = 0; g < 3; g++) begin
      wait_grant(12, ok, b, c);
      n_tests++;
      if (!ok || b !== exp_b[g] || c !== exp_c[g]) begin
        n_fail++;
        $display("FAIL order_grant%0d: got ok=%0d bus=%0d chan=%0d want bus=%0d chan=%0d",
                 g, ok, b, c, exp_b[g], exp_c[g]);
      end
      step();
      n_tests++;
      if (irq_valid !== 1'b0) begin
        n_fail++; $display("FAIL order_width%0d: got valid=%b want 0", g, irq_valid);
      end
    end
    drain();
  endtask

  task automatic test_enable_mask();
    bit         ok;
    logic [1:0] b;
    logic [3:0] c;
    en        = 9'h1FB;
    irq_ready = 1'b1;
    req_a     = 9'h024;
    for (int k = 0; k < 3; k++) begin
      wait_grant(12, ok, b, c);
      n_tests++;
      if (!ok || b !== 2'd0 || c !== 4'd5) begin
        n_fail++; $display("FAIL mask_a5_%0d: got ok=%0d bus=%0d chan=%0d want 0,5", k, ok, b, c);
      end
      step();
    end
    en = 9'h1FF;
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd0 || c !== 4'd2) begin
      n_fail++; $display("FAIL mask_reenable: got ok=%0d bus=%0d chan=%0d want 0,2", ok, b, c);
    end
    req_a = '0;
    step();
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd0 || c !== 4'd5) begin
      n_fail++; $display("FAIL mask_tail: got ok=%0d bus=%0d chan=%0d want 0,5", ok, b, c);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit         ok;
    int         bad;
    logic [1:0] b;
    logic [3:0] c;
    irq_ready = 1'b0;
    en        = 9'h1FF;
    req_a     = 9'h002;
    step();
    req_a = '0;
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd0 || c !== 4'd1) begin
      n_fail++; $display("FAIL bp_first: got ok=%0d bus=%0d chan=%0d want 0,1", ok, b, c);
    end
    req_a = 9'h001;
    step();
    req_a = '0;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      if (irq_valid !== 1'b1 || irq_bus !== 2'd0 || irq_chan !== 4'd1) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
    end
    irq_ready = 1'b1;
    step();
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd0 || c !== 4'd0) begin
      n_fail++; $display("FAIL bp_next: got ok=%0d bus=%0d chan=%0d want 0,0", ok, b, c);
    end
    drain();
  endtask

  task automatic test_aging();
    bit         ok;
    int         bad;
    logic [1:0] b;
    logic [3:0] c;
    do_reset();
    en        = 9'h1FF;
    irq_ready = 1'b1;
    req_a     = 9'h001;
    req_c     = 9'h080;
    step();
    req_c = '0;
    bad   = 0;
    for (int g = 0; g < 15; g++) begin
      wait_grant(12, ok, b, c);
      if (!ok || b !== 2'd0 || c !== 4'd0) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL aging_a_run: got %0d wrong A grants want 0", bad);
    end
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd2 || c !== 4'd7) begin
      n_fail++; $display("FAIL aging_promote: got ok=%0d bus=%0d chan=%0d want 2,7", ok, b, c);
    end
    req_c = 9'h080;
    step();
    step();
    req_c = '0;
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd0 || c !== 4'd0) begin
      n_fail++; $display("FAIL aging_cleared: got ok=%0d bus=%0d chan=%0d want 0,0", ok, b, c);
    end
    drain();
  endtask

  task automatic test_set_wins();
    bit         ok;
    bit         seen;
    logic [1:0] b;
    logic [3:0] c;
    en        = 9'h1FF;
    irq_ready = 1'b0;
    req_b     = 9'h004;
    step();
    req_b = '0;
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd1 || c !== 4'd2) begin
      n_fail++; $display("FAIL setwin_first: got ok=%0d bus=%0d chan=%0d want 1,2", ok, b, c);
    end
    irq_ready = 1'b1;
    req_b     = 9'h004;
    step();
    step();
    req_b = '0;
    step();
    n_tests++;
    if (irq_any !== 1'b1) begin
      n_fail++; $display("FAIL setwin_pending: got any=%b want 1", irq_any);
    end
    wait_grant(12, ok, b, c);
    n_tests++;
    if (!ok || b !== 2'd1 || c !== 4'd2) begin
      n_fail++; $display("FAIL setwin_regrant: got ok=%0d bus=%0d chan=%0d want 1,2", ok, b, c);
    end
    step();
    seen = 1'b0;
    repeat (10) begin
      step();
      if (irq_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || irq_any !== 1'b0) begin
      n_fail++; $display("FAIL setwin_cleared: got seen=%b any=%b want 0,0", seen, irq_any);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_enable_mask();
    test_backpressure();
    test_aging();
    test_set_wins();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
